// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor.
// State encoding and counter-width helper.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = x - y - bin.
// Combinational; counterpart of the full-adder cell.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b - bin, LSB first, one bit per clock.
// Valid/ready on both operand and result sides.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             d_bit;
  logic             br_nxt;
  logic             accept;

  full_subtractor u_cell (
    .x   (a_sr[0]),
    .y   (b_sr[0]),
    .bin (br),
    .d   (d_bit),
    .bout(br_nxt)
  );

  assign accept = (state == IDLE) && in_valid;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      cnt     <= '0;
      br      <= 1'b0;
    end else if (accept) begin
      a_sr    <= a;
      b_sr    <= b;
      diff_sr <= '0;
      cnt     <= '0;
      br      <= bin;
    end else if (state == RUN) begin
      // result bits enter at the MSB and settle LSB-aligned after WIDTH shifts
      diff_sr <= {d_bit, diff_sr[WIDTH-1:1]};
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      br      <= br_nxt;
      cnt     <= cnt + 1'b1;
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);
  assign diff      = diff_sr;
  assign bout      = br;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=8 directed/random and
// WIDTH=4 exhaustive, against a cycle-level arithmetic model.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] iv, ordy, bn, ir, ov, bsy, bo;
  logic [7:0] a0, b0, d0;
  logic [3:0] a1, b1, d1;

  int n_chk = 0;
  int n_err = 0;

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .resetn(rst_n),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a0), .b(b0), .bin(bn[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .diff(d0), .bout(bo[0]), .busy(bsy[0])
  );

  serial_subtractor #(.WIDTH(4)) u4 (
    .clk(clk), .resetn(rst_n),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a1), .b(b1), .bin(bn[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .diff(d1), .bout(bo[1]), .busy(bsy[1])
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s timeout act=0 exp=1", nm);
  endtask

  function automatic int sub_mod(input int w, input int av,
                                 input int bv, input int c);
    int m;
    m = 1 << w;
    return (((av - bv - c) % m) + m) % m;
  endfunction

  // behavioural model: one result per accepted operand set
  bit m_idle[2];
  int m_left[2];
  bit m_done[2];
  int m_diff[2];
  bit m_bout[2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_idle[i] <= 1'b1;
        m_left[i] <= 0;
        m_done[i] <= 1'b0;
        m_diff[i] <= 0;
        m_bout[i] <= 1'b0;
      end else if (m_idle[i]) begin
        if (iv[i]) begin
          m_idle[i] <= 1'b0;
          m_left[i] <= (i == 0) ? 8 : 4;
          m_diff[i] <= (i == 0) ?
            sub_mod(8, int'(a0), int'(b0), int'(bn[0])) :
            sub_mod(4, int'(a1), int'(b1), int'(bn[1]));
          m_bout[i] <= (i == 0) ?
            (int'(a0) < int'(b0) + int'(bn[0])) :
            (int'(a1) < int'(b1) + int'(bn[1]));
        end
      end else if (m_left[i] > 0) begin
        m_left[i] <= m_left[i] - 1;
        if (m_left[i] == 1) m_done[i] <= 1'b1;
      end else if (m_done[i] && ordy[i]) begin
        m_done[i] <= 1'b0;
        m_idle[i] <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("in_ready%0d", i), 32'(ir[i]), 32'(m_idle[i]));
      chk($sformatf("busy%0d", i), 32'(bsy[i]), 32'(m_left[i] > 0));
      chk($sformatf("out_valid%0d", i), 32'(ov[i]), 32'(m_done[i]));
      if (m_done[i]) begin
        chk($sformatf("diff%0d", i),
            (i == 0) ? 32'(d0) : 32'(d1), 32'(m_diff[i]));
        chk($sformatf("bout%0d", i), 32'(bo[i]), 32'(m_bout[i]));
      end
      if (!rst_n) begin
        chk($sformatf("rst_diff%0d", i),
            (i == 0) ? 32'(d0) : 32'(d1), 32'd0);
        chk($sformatf("rst_bout%0d", i), 32'(bo[i]), 32'd0);
      end
    end
  end

  task automatic op(input int i, input logic [7:0] a, input logic [7:0] b,
                    input logic c, input int hold, input bit poke,
                    output logic [7:0] d_o, output logic b_o,
                    output int lat);
    int n;
    n = 0;
    while (!ir[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ir[i]) tmo("in_ready_wait");
    if (i == 0) begin
      a0 = a;
      b0 = b;
    end else begin
      a1 = a[3:0];
      b1 = b[3:0];
    end
    bn[i] = c;
    iv[i] = 1'b1;
    @(negedge clk);
    iv[i] = 1'b0;
    a0 = 8'($urandom);
    b0 = 8'($urandom);
    lat = 1;
    while (!ov[i] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!ov[i]) tmo("out_valid_wait");
    lat = lat - 1;
    d_o = (i == 0) ? d0 : {4'b0, d1};
    b_o = bo[i];
    for (int k = 0; k < hold; k++) begin
      if (poke && k == 1) begin
        iv[i] = 1'b1;
        if (i == 0) a0 = 8'hAA;
      end else begin
        iv[i] = 1'b0;
      end
      @(negedge clk);
    end
    iv[i] = 1'b0;
    ordy[i] = 1'b1;
    @(negedge clk);
    ordy[i] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       bb;
    int         lat;
    rst_n = 1'b0;
    iv = '0;
    ordy = '0;
    bn = '0;
    a0 = '0;
    b0 = '0;
    a1 = '0;
    b1 = '0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", 32'(ir), 32'h3);
    chk("reset_out_valid", 32'(ov), 32'h0);
    chk("reset_busy", 32'(bsy), 32'h0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    op(0, 8'h05, 8'h03, 1'b0, 0, 1'b0, d, bb, lat);
    chk("basic_diff", 32'(d), 32'h02);
    chk("basic_bout", 32'(bb), 32'h0);
    chk("basic_latency", 32'(lat), 32'd8);

    op(0, 8'h00, 8'h01, 1'b0, 1, 1'b0, d, bb, lat);
    chk("under_diff", 32'(d), 32'hFF);
    chk("under_bout", 32'(bb), 32'h1);

    op(0, 8'h10, 8'h0F, 1'b1, 0, 1'b0, d, bb, lat);
    chk("bin1_diff", 32'(d), 32'h00);
    chk("bin1_bout", 32'(bb), 32'h0);

    op(0, 8'h00, 8'h00, 1'b1, 2, 1'b0, d, bb, lat);
    chk("bin2_diff", 32'(d), 32'hFF);
    chk("bin2_bout", 32'(bb), 32'h1);

    op(0, 8'h5A, 8'h33, 1'b0, 5, 1'b1, d, bb, lat);
    chk("bp_diff", 32'(d), 32'h27);
    chk("bp_bout", 32'(bb), 32'h0);

    // abort on the third RUN cycle
    a0 = 8'h01;
    b0 = 8'h02;
    bn[0] = 1'b0;
    iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(ov[0]), 32'h0);
    chk("abort_in_ready", 32'(ir[0]), 32'h1);
    chk("abort_busy", 32'(bsy[0]), 32'h0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    op(0, 8'h7F, 8'h80, 1'b0, 0, 1'b0, d, bb, lat);
    chk("post_rst_diff", 32'(d), 32'hFF);
    chk("post_rst_bout", 32'(bb), 32'h1);
    chk("post_rst_latency", 32'(lat), 32'd8);

    for (int r = 0; r < 40; r++) begin
      logic [7:0] ra, rb;
      logic       rc;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      op(0, ra, rb, rc, $urandom_range(0, 4), 1'($urandom), d, bb, lat);
      chk("rand_result", {23'd0, bb, d},
          32'(({1'b0, ra} - {1'b0, rb} - {8'd0, rc}) & 9'h1FF));
    end

    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        for (int c = 0; c < 2; c++) begin
          logic [4:0] g;
          g = 5'(x) - 5'(y) - 5'(c);
          op(1, 8'(x), 8'(y), 1'(c), $urandom_range(0, 3), 1'b0,
             d, bb, lat);
          chk("exh4", {27'd0, bb, d[3:0]}, 32'(g));
        end
      end
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
